// File: rtl/lbp_pkg.sv
// lbp_pkg: shared state encoding, row-register indices and default geometry for the LBP scan
package lbp_pkg;
    typedef enum logic [2:0] {S_IDLE, S_RD0, S_RD1, S_RD2, S_CAP, S_EMIT, S_DONE} state_t;
    localparam logic [1:0] ROW_TOP = 2'd0;
    localparam logic [1:0] ROW_MID = 2'd1;
    localparam logic [1:0] ROW_BOT = 2'd2;
    localparam int DEF_IMG_W = 128;
    localparam int DEF_IMG_H = 128;
    localparam int DEF_AW    = 14;
endpackage

// File: rtl/lbp_scan_cnt.sv
// lbp_scan_cnt: column/centre-row counters with a running (y-1)*IMG_W row base
module lbp_scan_cnt
    import lbp_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H,
    parameter int AW    = DEF_AW,
    parameter int XW    = $clog2(IMG_W),
    parameter int YW    = $clog2(IMG_H)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          step,
    output logic [XW-1:0] x,
    output logic [AW-1:0] base,
    output logic          last
);
    logic [YW-1:0] y;

    assign last = (x == XW'(IMG_W - 1)) && (y == YW'(IMG_H - 2));

    // step one column; wrapping the column moves the base down a whole image row
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x    <= '0;
            y    <= YW'(1);
            base <= '0;
        end else if (clr) begin
            x    <= '0;
            y    <= YW'(1);
            base <= '0;
        end else if (step) begin
            if (x == XW'(IMG_W - 1)) begin
                x    <= '0;
                y    <= y + YW'(1);
                base <= base + AW'(IMG_W);
            end else begin
                x    <= x + XW'(1);
            end
        end
    end
endmodule

// File: rtl/lbp_scan_ctrl.sv
// lbp_scan_ctrl: raster-scan read sequencer and window presenter for the 3x3 LBP datapath
module lbp_scan_ctrl
    import lbp_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H,
    parameter int AW    = DEF_AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          gray_ready,
    output logic          gray_req,
    output logic [AW-1:0] gray_addr,
    output logic          dat_vld,
    output logic [1:0]    dat_row,
    output logic          win_valid,
    output logic [AW-1:0] win_addr,
    input  logic          out_ready,
    output logic          busy,
    output logic          finish
);
    localparam int XW = $clog2(IMG_W);

    state_t        state;
    logic [XW-1:0] x;
    logic [AW-1:0] base;
    logic [AW-1:0] row_off;
    logic [1:0]    row;
    logic          last;
    logic          rd;
    logic          clr;
    logic          step;

    assign rd        = state inside {S_RD0, S_RD1, S_RD2};
    assign row       = state == S_RD1 ? ROW_MID : state == S_RD2 ? ROW_BOT : ROW_TOP;
    assign row_off   = state == S_RD1 ? AW'(IMG_W) : state == S_RD2 ? AW'(2 * IMG_W) : '0;
    assign gray_req  = rd & gray_ready;
    assign gray_addr = rd ? base + row_off + AW'(x) : '0;
    assign win_valid = state == S_EMIT;
    assign win_addr  = win_valid ? base + AW'(IMG_W) + AW'(x) - AW'(1) : '0;
    assign busy      = !(state inside {S_IDLE, S_DONE});
    assign finish    = state == S_DONE;
    assign clr       = !busy & start;
    assign step      = (state == S_CAP && x < XW'(2)) || (win_valid && out_ready && !last);

    lbp_scan_cnt #(.IMG_W(IMG_W), .IMG_H(IMG_H), .AW(AW)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .step  (step),
        .x     (x),
        .base  (base),
        .last  (last)
    );

    // scan FSM plus the one-deep read-return pipe that tags returning data with its row
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            dat_vld <= 1'b0;
            dat_row <= ROW_TOP;
        end else begin
            dat_vld <= gray_req;
            dat_row <= row;
            case (state)
                S_IDLE, S_DONE: if (start) state <= S_RD0;
                S_RD0:  if (gray_ready) state <= S_RD1;
                S_RD1:  if (gray_ready) state <= S_RD2;
                S_RD2:  if (gray_ready) state <= S_CAP;
                S_CAP:  state <= x >= XW'(2) ? S_EMIT : S_RD0;
                S_EMIT: if (out_ready) state <= last ? S_DONE : S_RD0;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
